spi_master_ctrl: RTL and testbench

- Host-side SPI initiator that drives the team's SPI slave/RAM block from the opposite end of the link.
- Accepts a 10-bit command word over a valid/ready handshake and serialises it MSB first on mosi while holding ss_n low.
- For read-data commands (tx_data[9:8]==2'b11) it keeps ss_n low, skips one turnaround cycle, then deserialises RX_BITS bits from miso and presents them on rx_data.
- SPI bit clock is clk itself; the slave samples mosi and drives miso on the same clk.

---
 rtl/spi_master_ctrl_if.sv | 26 ++
 rtl/spi_master_ctrl.sv | 101 ++++++++++
 tb/tb_spi_master_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host-side bundle for the SPI initiator: command handshake, read-back and
// the serial link pins. The controller uses the slave modport; the host/bench uses master.
interface spi_master_ctrl_if #(
   parameter int TX_BITS = 10,
   parameter int RX_BITS = 8
) ();
   logic               tx_valid;
   logic [TX_BITS-1:0] tx_data;
   logic               tx_ready;
   logic               rx_valid;
   logic [RX_BITS-1:0] rx_data;
   logic               done;
   logic               ss_n;
   logic               mosi;
   logic               miso;

   modport master (
      output tx_valid, tx_data, miso,
      input  tx_ready, rx_valid, rx_data, done, ss_n, mosi
   );

   modport slave (
      input  tx_valid, tx_data, miso,
      output tx_ready, rx_valid, rx_data, done, ss_n, mosi
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises a command word MSB first, and for read commands
// skips one turnaround cycle and then deserialises the slave's reply.
module spi_master_ctrl #(
   parameter int TX_BITS  = 10,
   parameter int RX_BITS  = 8,
   parameter int CNT_BITS = 4
) (
   input  logic           clk,
   input  logic           rstn,
   spi_master_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_TURN,
      S_RECV,
      S_END
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic [TX_BITS-1:0]   tx_sh_q, tx_sh_d;
   logic [RX_BITS-1:0]   rx_sh_q, rx_sh_d;
   logic [RX_BITS-1:0]   rx_data_q, rx_data_d;
   logic                 is_read_q, is_read_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         is_read_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         is_read_q <= is_read_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      is_read_d = is_read_q;
      case (state_q)
         S_IDLE: begin
            if (bus.tx_valid) begin
               state_d   = S_SEND;
               cnt_d     = CNT_BITS'(TX_BITS - 1);
               tx_sh_d   = bus.tx_data;
               is_read_d = (bus.tx_data[TX_BITS-1 -: 2] == 2'b11);
            end
         end
         S_SEND: begin
            tx_sh_d = {tx_sh_q[TX_BITS-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = is_read_q ? S_TURN : S_END;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_TURN: begin
            cnt_d   = CNT_BITS'(RX_BITS - 1);
            state_d = S_RECV;
         end
         S_RECV: begin
            rx_sh_d = {rx_sh_q[RX_BITS-2:0], bus.miso};
            if (cnt_q == '0) begin
               // Publish the completed byte on the same edge that enters END.
               rx_data_d = {rx_sh_q[RX_BITS-2:0], bus.miso};
               state_d   = S_END;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_END: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode straight from state so reset forces ss_n high without waiting for a clock.
   assign bus.tx_ready = (state_q == S_IDLE);
   assign bus.ss_n     = !((state_q == S_SEND) || (state_q == S_TURN) || (state_q == S_RECV));
   assign bus.mosi     = (state_q == S_SEND) && tx_sh_q[TX_BITS-1];
   assign bus.done     = (state_q == S_END);
   assign bus.rx_valid = (state_q == S_END) && is_read_q;
   assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed scenarios plus random frames checked
// against a frame-level model of the expected pin activity.
module tb_spi_master_ctrl;

   logic clk;
   logic rstn;
   int   errors;
   int   checks;
   logic [7:0] last_rx;

   spi_master_ctrl_if #(.TX_BITS(10), .RX_BITS(8)) bus ();

   spi_master_ctrl #(.TX_BITS(10), .RX_BITS(8), .CNT_BITS(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One frame from handshake through the following IDLE cycle; entered and left at a negedge.
   task automatic frame(input logic [9:0] w, input logic [7:0] b,
                        input bit keep, input logic [9:0] nw);
      bit rd;
      int n;
      rd = (w[9:8] == 2'b11);
      n  = rd ? 19 : 10;
      bus.tx_valid = 1'b1;
      bus.tx_data  = w;
      chk("ready_before_frame", {31'd0, bus.tx_ready}, 32'd1);
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("ss_n_low", {31'd0, bus.ss_n}, 32'd0);
         chk("mosi_bit", {31'd0, bus.mosi}, (i < 10) ? {31'd0, w[9-i]} : 32'd0);
         chk("done_quiet", {31'd0, bus.done}, 32'd0);
         chk("rx_valid_quiet", {31'd0, bus.rx_valid}, 32'd0);
         chk("ready_busy", {31'd0, bus.tx_ready}, 32'd0);
         if (rd && i >= 11) bus.miso = b[7-(i-11)];
         else               bus.miso = 1'($urandom);
         if (i == n - 1) begin
            bus.tx_valid = keep;
            bus.tx_data  = keep ? nw : 10'($urandom);
         end else begin
            bus.tx_valid = 1'($urandom);
            bus.tx_data  = 10'($urandom);
         end
      end
      @(negedge clk);
      chk("end_ss_n", {31'd0, bus.ss_n}, 32'd1);
      chk("end_mosi", {31'd0, bus.mosi}, 32'd0);
      chk("end_done", {31'd0, bus.done}, 32'd1);
      chk("end_rx_valid", {31'd0, bus.rx_valid}, {31'd0, rd});
      if (rd) last_rx = b;
      chk("end_rx_data", {24'd0, bus.rx_data}, {24'd0, last_rx});
      chk("end_ready", {31'd0, bus.tx_ready}, 32'd0);
      @(negedge clk);
      chk("idle_ss_n", {31'd0, bus.ss_n}, 32'd1);
      chk("idle_done", {31'd0, bus.done}, 32'd0);
      chk("idle_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
      chk("idle_ready", {31'd0, bus.tx_ready}, 32'd1);
      chk("idle_rx_data", {24'd0, bus.rx_data}, {24'd0, last_rx});
   endtask

   initial begin
      logic [9:0] w;
      logic [9:0] nw;
      bit         keep;
      errors       = 0;
      checks       = 0;
      last_rx      = 8'h00;
      rstn         = 1'b0;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 10'h3FF;
      bus.miso     = 1'b0;

      // Reset held with tx_valid high: nothing may start.
      repeat (3) begin
         @(negedge clk);
         chk("rst_ss_n", {31'd0, bus.ss_n}, 32'd1);
         chk("rst_mosi", {31'd0, bus.mosi}, 32'd0);
         chk("rst_done", {31'd0, bus.done}, 32'd0);
         chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
         chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
      end
      bus.tx_valid = 1'b0;
      rstn = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
         chk("post_rst_ss_n", {31'd0, bus.ss_n}, 32'd1);
      end

      // Write address, then read-back of C3.
      frame(10'b00_1010_0101, 8'h00, 1'b0, 10'h000);
      frame(10'b11_0000_0000, 8'hC3, 1'b0, 10'h000);

      // Back-to-back with tx_valid held high.
      frame(10'h0AA, 8'h00, 1'b1, 10'h1FF);
      frame(10'h1FF, 8'h00, 1'b0, 10'h000);

      // Reset during RECV bit 3 of a read.
      bus.tx_valid = 1'b1;
      bus.tx_data  = 10'h300;
      @(posedge clk);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         bus.miso = 1'b1;
      end
      chk("mid_ss_n_before", {31'd0, bus.ss_n}, 32'd0);
      #1 rstn = 1'b0;
      #1;
      chk("mid_ss_n_async", {31'd0, bus.ss_n}, 32'd1);
      chk("mid_mosi", {31'd0, bus.mosi}, 32'd0);
      chk("mid_rx_data", {24'd0, bus.rx_data}, 32'd0);
      chk("mid_done", {31'd0, bus.done}, 32'd0);
      chk("mid_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
      last_rx = 8'h00;
      @(negedge clk);
      rstn = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("after_rst_done", {31'd0, bus.done}, 32'd0);
         chk("after_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
         chk("after_rst_ss_n", {31'd0, bus.ss_n}, 32'd1);
      end
      frame(10'h300, 8'h5A, 1'b0, 10'h000);

      // Random frames, random command types, random gaps or held valid.
      w = 10'($urandom);
      for (int k = 0; k < 24; k++) begin
         nw   = 10'($urandom);
         keep = 1'($urandom);
         frame(w, 8'($urandom), keep, nw);
         if (!keep) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               chk("gap_ss_n", {31'd0, bus.ss_n}, 32'd1);
            end
         end
         w = nw;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
